// File: rtl/toggle_count_engine_pkg.sv
// Shared types and constants for the toggle-count engine.
// Imported by the engine top level and the testbench.
package toggle_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SER = 1'b1;

endpackage

// File: rtl/toggle_count_engine_if.sv
// Start/busy/done handshake and data bus between a controller and the toggle-count engine.
interface toggle_count_engine_if #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned CW          = 8,
    parameter int unsigned SCALE_SHIFT = 1
) ();

    logic                      start;
    logic                      mode;
    logic [WIDTH-1:0]          par_in;
    logic                      d;
    logic                      busy;
    logic                      done;
    logic [CW+SCALE_SHIFT-1:0] count;
    logic                      ovf;

    modport master (
        output start, mode, par_in, d,
        input  busy, done, count, ovf
    );

    modport slave (
        input  start, mode, par_in, d,
        output busy, done, count, ovf
    );

endinterface

// File: rtl/toggle_count_engine_shift_reg.sv
// Shift register plus toggle flop: parallel load, serial toggle fill, or MSB-first shift-out.
module toggle_shift_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             clear_i,
    input  logic             shift_in_toggle_i,
    input  logic             d_i,
    input  logic             shift_out_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic             t_q, t_d;

    // The updated toggle value (not the old one) is what enters the register.
    always_comb begin
        sr_d = sr_q;
        t_d  = t_q;
        if (clear_i) begin
            sr_d = '0;
            t_d  = 1'b0;
        end else if (load_i) begin
            sr_d = par_i;
        end else if (shift_in_toggle_i) begin
            t_d  = t_q ^ d_i;
            sr_d = {sr_q[WIDTH-2:0], t_q ^ d_i};
        end else if (shift_out_i) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
            t_q  <= 1'b0;
        end else begin
            sr_q <= sr_d;
            t_q  <= t_d;
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/toggle_count_engine.sv
// Ones-counting engine: load or toggle-fill a word, shift it out MSB-first, report scaled count.
// Build option TOGGLE_COUNT_SAT_EN: ones counter saturates instead of wrapping.
module toggle_count_engine
    import toggle_count_pkg::*;
#(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned CW          = 8,
    parameter int unsigned SCALE_SHIFT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    toggle_count_engine_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(WIDTH + 1);
    localparam int unsigned OUT_W = CW + SCALE_SHIFT;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CW-1:0]    ONES_MAX = '1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_FILL  = ST_FILL;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CW-1:0]    ones_q, ones_d;
    logic             run_ovf_q, run_ovf_d;
    logic [OUT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, done_q;

    logic sr_load_c, sr_clear_c, sr_fill_c, sr_shift_c;
    logic sr_msb;

    toggle_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk_i             (clock),
        .rst_i             (reset),
        .load_i            (sr_load_c),
        .par_i             (bus.par_in),
        .clear_i           (sr_clear_c),
        .shift_in_toggle_i (sr_fill_c),
        .d_i               (bus.d),
        .shift_out_i       (sr_shift_c),
        .msb_o             (sr_msb)
    );

    // Next-state, counter and result logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ones_d     = ones_q;
        run_ovf_d  = run_ovf_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        sr_load_c  = 1'b0;
        sr_clear_c = 1'b0;
        sr_fill_c  = 1'b0;
        sr_shift_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ones_d    = '0;
                    idx_d     = '0;
                    run_ovf_d = 1'b0;
                    if (bus.mode == MODE_PAR) begin
                        sr_load_c = 1'b1;
                        state_d   = S_SHIFT;
                    end else begin
                        sr_clear_c = 1'b1;
                        state_d    = S_FILL;
                    end
                end
            end
            S_FILL: begin
                sr_fill_c = 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_SHIFT: begin
                sr_shift_c = 1'b1;
                if (sr_msb) begin
                    if (ones_q == ONES_MAX) begin
                        run_ovf_d = 1'b1;
`ifdef TOGGLE_COUNT_SAT_EN
                        ones_d = ONES_MAX;
`else
                        ones_d = '0;
`endif
                    end else begin
                        ones_d = ones_q + CW'(1);
                    end
                end
                // Result captures the final bit's contribution on the same edge.
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                    count_d = OUT_W'(ones_d) << SCALE_SHIFT;
                    ovf_d   = run_ovf_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ones_q    <= '0;
            run_ovf_q <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ones_q    <= ones_d;
            run_ovf_q <= run_ovf_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_toggle_count_engine.sv
// Randomised self-checking bench: a 64-bit/CW=8 engine and a 16-bit/CW=3 engine against a popcount model.
module tb_toggle_count_engine;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    toggle_count_engine_if #(.WIDTH(64), .CW(8), .SCALE_SHIFT(1)) ifa ();
    toggle_count_engine_if #(.WIDTH(16), .CW(3), .SCALE_SHIFT(1)) ifb ();

    toggle_count_engine #(.WIDTH(64), .CW(8), .SCALE_SHIFT(1)) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (ifa)
    );

    toggle_count_engine #(.WIDTH(16), .CW(3), .SCALE_SHIFT(1)) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (ifb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result from a total ones figure, independent of how the bits were counted.
    function automatic logic [63:0] model_count(input int ones, input int cw, input int sh);
        int lim = (1 << cw) - 1;
        int v   = ones;
        if (ones > lim) begin
`ifdef TOGGLE_COUNT_SAT_EN
            v = lim;
`else
            v = ones % (1 << cw);
`endif
        end
        return 64'(v) << sh;
    endfunction

    function automatic int serial_ones(input logic [63:0] dseq);
        int   n = 0;
        logic t = 1'b0;
        for (int i = 0; i < 64; i++) begin
            t = t ^ dseq[i];
            if (t) n++;
        end
        return n;
    endfunction

    task automatic run_a(input logic m, input logic [63:0] word, input logic [63:0] dseq, input bit poke);
        int ones   = (m == 1'b0) ? $countones(word) : serial_ones(dseq);
        int lat    = (m == 1'b0) ? 64 : 128;
        int cycles = 0;
        @(posedge clk); #1;
        ifa.start  = 1'b1;
        ifa.mode   = m;
        ifa.par_in = word;
        ifa.d      = dseq[0];
        @(posedge clk); #1;
        ifa.start  = 1'b0;
        ifa.mode   = ~m;
        ifa.par_in = {$urandom, $urandom};
        check("busy_rise", 64'(ifa.busy), 64'd1);
        while (!ifa.done && cycles < lat + 8) begin
            ifa.d     = (cycles < 64) ? dseq[cycles] : 1'($urandom);
            ifa.start = poke && cycles > 0 && cycles < lat - 3 && ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
            cycles++;
        end
        ifa.start = 1'b0;
        check("latency", 64'(cycles), 64'(lat));
        check("count", 64'(ifa.count), model_count(ones, 8, 1));
        check("ovf", 64'(ifa.ovf), 64'(ones > 255));
        @(posedge clk); #1;
        check("done_width", 64'(ifa.done), 64'd0);
        check("busy_fall", 64'(ifa.busy), 64'd0);
    endtask

    task automatic run_b(input logic [15:0] word);
        int ones   = $countones(word);
        int cycles = 0;
        @(posedge clk); #1;
        ifb.start  = 1'b1;
        ifb.mode   = 1'b0;
        ifb.par_in = word;
        @(posedge clk); #1;
        ifb.start  = 1'b0;
        ifb.par_in = 16'($urandom);
        while (!ifb.done && cycles < 24) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("b_latency", 64'(cycles), 64'd16);
        check("b_count", 64'(ifb.count), model_count(ones, 3, 1));
        check("b_ovf", 64'(ifb.ovf), 64'(ones > 7));
        @(posedge clk); #1;
    endtask

    task automatic mid_run_reset();
        int seen_done = 0;
        @(posedge clk); #1;
        ifa.start  = 1'b1;
        ifa.mode   = 1'b0;
        ifa.par_in = '1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ifa.done) seen_done++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", 64'(ifa.busy), 64'd0);
        check("rst_count", 64'(ifa.count), 64'd0);
        check("rst_ovf", 64'(ifa.ovf), 64'd0);
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (ifa.done) seen_done++;
        end
        check("rst_no_done", 64'(seen_done), 64'd0);
    endtask

    task automatic held_start(input logic [63:0] word, input logic [63:0] prev_count);
        int last_done = -1;
        int pulses    = 0;
        @(posedge clk); #1;
        ifa.start  = 1'b1;
        ifa.mode   = 1'b0;
        ifa.par_in = word;
        for (int c = 0; c < 3 * 66 + 4; c++) begin
            @(posedge clk); #1;
            if (c == 10) check("held_count_hold", 64'(ifa.count), prev_count);
            if (ifa.done) begin
                pulses++;
                check("held_count", 64'(ifa.count), model_count($countones(word), 8, 1));
                if (last_done >= 0) check("held_gap", 64'(c - last_done), 64'd66);
                last_done = c;
            end
        end
        ifa.start = 1'b0;
        check("held_pulses", 64'(pulses), 64'd3);
        for (int i = 0; i < 70; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] w;
        logic [63:0] ds;
        rst        = 1'b1;
        ifa.start  = 1'b0;
        ifa.mode   = 1'b0;
        ifa.par_in = '0;
        ifa.d      = 1'b0;
        ifb.start  = 1'b0;
        ifb.mode   = 1'b0;
        ifb.par_in = '0;
        ifb.d      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_a_busy", 64'(ifa.busy), 64'd0);
        check("rst_a_done", 64'(ifa.done), 64'd0);
        check("rst_a_count", 64'(ifa.count), 64'd0);
        check("rst_a_ovf", 64'(ifa.ovf), 64'd0);
        check("rst_b_count", 64'(ifb.count), 64'd0);

        run_a(1'b0, 64'hFFFF_0000_0000_000F, '0, 1'b0);
        run_a(1'b0, 64'h0, '0, 1'b0);
        run_a(1'b0, '1, '0, 1'b1);
        run_a(1'b1, '0, '1, 1'b0);
        run_a(1'b1, '0, '0, 1'b1);

        run_b(16'hFFFF);
        run_b(16'h0007);
        run_b(16'h00FF);
        for (int i = 0; i < 6; i++) run_b(16'($urandom));

        for (int i = 0; i < 12; i++) begin
            w  = {$urandom, $urandom};
            if (i % 3 == 1) w = w & {$urandom, $urandom};
            if (i % 3 == 2) w = w | {$urandom, $urandom};
            ds = {$urandom, $urandom};
            run_a(1'($urandom), w, ds, 1'b1);
        end

        mid_run_reset();
        held_start(64'h0123_4567_89AB_CDEF, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toggle_count_engine.md
# toggle_count_engine

Parametrised ones-counting engine for a toggle-encoded or parallel-loaded data word. A word is either loaded in parallel or built serially from a T-flop driven by `d`. It is then shifted out MSB-first while the ones are counted. The count is reported scaled by a power of two. It replaces the fixed 64-bit, free-running toggle counter with a start/busy/done handshake, a single rising-edge clock domain, overflow reporting and configurable widths.

## Interface

Parameters:
- `WIDTH`, 64: shift-register length in bits (≥2)
- `CW`, 8: ones-counter width (≥1)
- `SCALE_SHIFT`, 1: result = ones << SCALE_SHIFT (≥0)

Ports:
- `clock`  in  1  single clock; all state updates on rising edge only
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a run; honoured only in IDLE
- `mode`  in  1  0 = parallel load from `par_in`; 1 = serial toggle capture from `d`
- `par_in`  in  WIDTH  parallel word, sampled on the start edge
- `d`  in  1  toggle input, used in FILL
- `busy`  out  1  high in FILL, SHIFT and DONE
- `done`  out  1  one-cycle pulse while in DONE
- `count`  out  CW+SCALE_SHIFT  last result, held until the next completion
- `ovf`  out  1  last run exceeded 2^CW−1 ones; held with `count`

## Operation

- FSM states: IDLE, FILL, SHIFT, DONE.
- **IDLE, `start`=1, `mode`=0:**
  - sr ← par_in; ones ← 0; idx ← 0
  - next state SHIFT
- **IDLE, `start`=1, `mode`=1:**
  - sr ← 0; t ← 0; ones ← 0; idx ← 0
  - next state FILL
- **FILL:** each edge, t ← t^d and sr ← {sr[WIDTH-2:0], t^d}, so the updated toggle value is shifted in. After WIDTH edges: idx ← 0, go to SHIFT.
- **SHIFT:** each edge:
  - if sr[WIDTH-1]=1, increment ones
  - sr ← {sr[WIDTH-2:0], 1'b0}
  - after WIDTH edges go to DONE
- **On the edge entering DONE:**
  - count ← final ones << SCALE_SHIFT
  - ovf ← 1 if any increment exceeded 2^CW−1
- **DONE:** `done`=1 for exactly one cycle, then unconditionally to IDLE.
- `start` outside IDLE is ignored. `mode`, `par_in` and `start` are not re-sampled mid-run.
- `idx` width: $clog2(WIDTH+1).
- **Reset:**
  - state IDLE; sr, t, ones, idx = 0
  - `busy`=0, `done`=0, `count`=0, `ovf`=0
- Reset mid-run aborts the run immediately, with no `done` pulse and `count` cleared.

## Timing

- Start edge E0. Parallel mode: SHIFT covers E1..E_WIDTH; `done`=1 in the cycle after E_WIDTH (WIDTH+1 cycles after E0).
- Serial mode: FILL covers E1..E_WIDTH, SHIFT covers E_WIDTH+1..E_2·WIDTH; `done` after 2·WIDTH+1 cycles.
- `busy` rises the cycle after E0 and falls in the cycle after DONE.
- `count`/`ovf` change only on the edge entering DONE, or on reset.
- If `start` is held high through DONE, the next run starts on the first IDLE edge. The minimum gap between runs is 1 idle cycle.

## Configuration

- Macro: `TOGGLE_COUNT_SAT_EN`.
- **Defined:** ones counter saturates at 2^CW−1; `ovf`=1 if saturation was reached.
- **Undefined:** ones counter wraps modulo 2^CW; `ovf`=1 if a wrap occurred.
- Output scaling and timing are identical in both builds.

## Structure

- Package `toggle_count_pkg`:
  - state enum typedef (IDLE, FILL, SHIFT, DONE)
  - mode constants MODE_PAR=0, MODE_SER=1
- Sub-module `toggle_shift_reg`, parametrised by WIDTH. It contains the T-flop `t` and the shift register, with controls load/clear/shift_in_toggle/shift_out and outputs msb.
- The top level holds the FSM, idx counter, ones counter, saturation/wrap logic and result registers.

## Test plan

- Reset, then parallel run with `par_in`=64'hFFFF_0000_0000_000F → `done` 65 cycles after the start edge, `count`=40, `ovf`=0.
- Parallel 64'h0 → `count`=0; parallel all-ones → `count`=128, `ovf`=0.
- Serial run with `d`=1 for all 64 FILL cycles (bits 1,0,1,…) → 32 ones, `count`=64, `done` at cycle 129; with `d`=0 throughout → `count`=0.
- WIDTH=16, CW=3, all-ones:
  - without macro → `count`=0 (16 mod 8 = 0, ×2), `ovf`=1
  - with `TOGGLE_COUNT_SAT_EN` → `count`=14, `ovf`=1
- Assert `reset` at SHIFT cycle 10 → next cycle `busy`=0, `count`=0, no `done` pulse; a `start` pulse mid-run is ignored (run length unchanged).
- `start` held high continuously → `done` pulses every WIDTH+2 cycles in parallel mode; `count` updates only on those edges.
